wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage: buffers MEM-stage results in order and drives the register-file write port
//  (destWB/resultWB/writeBackEn); the register file commits them on the following negedge.
//  Load results arrive late from data memory and are merged into their buffered entry.
//  Writes to R15 are redirected to the PC-write interface.
//  Also exports a pending-write mask to the hazard unit.
// PARAMETERS
//  DEPTH   2   result buffer entries (power of 2, >=2)
//  DATA_W  32  datapath width
//  REG_AW  4   register index width
// PORTS
//  clk            in   1       clock; all state on posedge
//  rst            in   1       synchronous, active-high reset
//  in_valid       in   1       MEM stage presents a result
//  in_ready       out  1       buffer can accept (count < DEPTH)
//  in_wb_en       in   1       result writes a register
//  in_is_load     in   1       value comes from data memory, not alu
//  in_dest        in   REG_AW  destination register index
//  in_alu         in   DATA_W  ALU result
//  mem_rdata_vld  in   1       load data valid this cycle
//  mem_rdata      in   DATA_W  load data
//  destWB         out  REG_AW  to register file
//  resultWB       out  DATA_W  to register file
//  writeBackEn    out  1       to register file; one-cycle pulse per write
//  pc_wr_en       out  1       one-cycle pulse: write to R15
//  pc_wr_value    out  DATA_W  new PC value
//  pending_mask   out  15      bit r set if any buffered entry (incl. retiring output) writes Rr, r<15
//  rdata_orphan   out  1       sticky: mem_rdata_vld seen with no load awaiting data
// BEHAVIOUR
//  - Reset: buffer emptied, count=0.
//    All outputs 0: destWB, resultWB, writeBackEn, pc_wr_en, pc_wr_value, pending_mask, rdata_orphan.
//  - Accept: entry {wb_en,is_load,dest,alu,data,data_ok} written at tail when in_valid&&in_ready.
//    data_ok=!is_load. in_ready depends only on count (no comb path from retire).
//  - Load data: mem_rdata_vld writes mem_rdata into the oldest entry with is_load&&!data_ok
//    and sets its data_ok. This includes an entry being accepted the same cycle if no older one waits.
//    No such entry: data dropped, rdata_orphan<=1 until rst.
//  - Retire: head retires at posedge when valid && data_ok (incl. data arriving this cycle, bypassed).
//    At most one retire per cycle, strictly in order.
//    A head load without data blocks younger entries.
//  - Retire outputs are registered, valid exactly the cycle after the retire edge:
//    - wb_en && dest!=15: destWB=dest, resultWB=(is_load?data:alu), writeBackEn=1.
//    - wb_en && dest==15: writeBackEn=0, pc_wr_en=1, pc_wr_value=value.
//    - !wb_en: entry retires silently, all enables 0.
//    - No retire: enables 0; destWB/resultWB hold their previous values.
//  - Latency: ALU entry accepted at edge N into an empty buffer -> writeBackEn high in cycle N+1..N+2.
//    Load: write pulse is the cycle after the edge where data arrives (at the earliest N+1..N+2).
//  - Simultaneous accept+retire: count unchanged. Full and retiring: in_ready still 0 that cycle.
//  - Pointers wrap modulo DEPTH.
//  - pending_mask: OR over valid buffered entries with wb_en&&dest<15, plus the register currently
//    driven with writeBackEn=1. Recomputed combinationally from state.
//  - Reset mid-operation: all buffered entries discarded, nothing written. Subsequent
//    mem_rdata_vld for discarded loads sets rdata_orphan.
// STRUCTURE
//  - wb_pkg: wb_entry_t struct (wb_en,is_load,dest,alu,data,data_ok), PC_IDX=4'd15, NUM_GPR=15.
//  - Sub-module wb_retire_fifo: DEPTH-entry circular buffer; exposes head, count,
//    and a per-entry load-data write port.
//  - Top: load-data routing, retire/redirect logic, output registers, pending_mask, orphan flag.
// TESTING
//  - Reset: hold rst 2 cycles -> all outputs 0, in_ready=1, pending_mask=0.
//  - ALU write: accept {wb_en=1,dest=3,alu=32'h1234} at edge N -> cycle N+1..N+2:
//    destWB=3, resultWB=32'h1234, writeBackEn=1; pending_mask[3]=1 from N until pulse ends.
//  - Load stall: load dest=5, then ALU dest=6 alu=7, data 32'hCAFE 3 cycles later.
//    Expect: no write until data arrives; then R5=32'hCAFE, R6=7 on consecutive cycles;
//    in_ready=0 while full.
//  - Early data: load accepted same cycle as mem_rdata_vld=1, mem_rdata=32'h55 -> writes 32'h55, no orphan.
//  - R15: accept {wb_en=1,dest=15,alu=32'h100} -> pc_wr_en=1, pc_wr_value=32'h100, writeBackEn=0.
//  - Reset mid-load: rst while load waits, then mem_rdata_vld -> no write, rdata_orphan=1.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback stage
package wb_pkg;

    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_REG_AW = 4;

    localparam logic [ENTRY_REG_AW-1:0] PC_IDX = 4'd15;
    localparam int NUM_GPR = 15;

    // One buffered MEM-stage result; data/data_ok are filled in later for loads
    typedef struct packed {
        logic                    wb_en;
        logic                    is_load;
        logic [ENTRY_REG_AW-1:0] dest;
        logic [ENTRY_DATA_W-1:0] alu;
        logic [ENTRY_DATA_W-1:0] data;
        logic                    data_ok;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-side, load-data and register-file signals of the writeback stage
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
);
    import wb_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_wb_en;
    logic              in_is_load;
    logic [REG_AW-1:0] in_dest;
    logic [DATA_W-1:0] in_alu;
    logic              mem_rdata_vld;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_AW-1:0] destWB;
    logic [DATA_W-1:0] resultWB;
    logic              writeBackEn;
    logic              pc_wr_en;
    logic [DATA_W-1:0] pc_wr_value;
    logic [NUM_GPR-1:0] pending_mask;
    logic              rdata_orphan;

    // Upstream pipeline / memory / register-file side
    modport master (
        output in_valid, in_wb_en, in_is_load, in_dest, in_alu, mem_rdata_vld, mem_rdata,
        input  in_ready, destWB, resultWB, writeBackEn, pc_wr_en, pc_wr_value,
               pending_mask, rdata_orphan
    );

    // Writeback stage side
    modport slave (
        input  in_valid, in_wb_en, in_is_load, in_dest, in_alu, mem_rdata_vld, mem_rdata,
        output in_ready, destWB, resultWB, writeBackEn, pc_wr_en, pc_wr_value,
               pending_mask, rdata_orphan
    );

endinterface

// File: rtl/wb_retire_fifo.sv
// rtl/wb_retire_fifo.sv - in-order circular result buffer with a load-data write port
module wb_retire_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    input  logic                    ld_wr_en,
    input  logic [PW-1:0]           ld_wr_idx,
    input  logic [ENTRY_DATA_W-1:0] ld_wr_data,
    output logic [PW-1:0]           head_ptr,
    output wb_entry_t               head,
    output wb_entry_t               entries [DEPTH],
    output logic [DEPTH-1:0]        entry_vld,
    output logic [CW-1:0]           count
);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    // Pointer/occupancy bookkeeping plus entry writes; push only targets the free
    // tail slot, so it never collides with a load-data write or the popped head
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (ld_wr_en) begin
                mem[ld_wr_idx].data    <= ld_wr_data;
                mem[ld_wr_idx].data_ok <= 1'b1;
            end
            if (push) begin
                mem[tail_q]   <= push_entry;
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head_ptr  = head_q;
    assign head      = mem[head_q];
    assign entries   = mem;
    assign entry_vld = vld_q;
    assign count     = count_q;

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: buffering, load-data merge, retire and R15 redirect
module wb_stage
    import wb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    head_ptr;
    wb_entry_t        head;
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] entry_vld;
    logic [CW-1:0]    count;

    logic          push;
    logic          pop;
    wb_entry_t     push_entry;
    logic          ld_found;
    logic [PW-1:0] ld_idx;
    logic          ld_wr_en;
    logic          ld_to_new;
    logic          orphan_set;
    logic          head_bypass;
    logic [DATA_W-1:0] head_value;

    logic [REG_AW-1:0]  dest_q;
    logic [DATA_W-1:0]  result_q;
    logic               wbe_q;
    logic               pce_q;
    logic [DATA_W-1:0]  pcv_q;
    logic               orphan_q;
    logic [NUM_GPR-1:0] mask;

    wb_retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .ld_wr_en   (ld_wr_en),
        .ld_wr_idx  (ld_idx),
        .ld_wr_data (bus.mem_rdata),
        .head_ptr   (head_ptr),
        .head       (head),
        .entries    (entries),
        .entry_vld  (entry_vld),
        .count      (count)
    );

    // Readiness comes from occupancy alone so it never depends on this cycle's retire
    assign bus.in_ready = (count < CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;

    // Find the oldest buffered load still waiting for data, walking from the head
    always_comb begin
        logic [PW-1:0] idx;
        ld_found = 1'b0;
        ld_idx   = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PW'(k);
            if (!ld_found && entry_vld[idx] && entries[idx].is_load && !entries[idx].data_ok) begin
                ld_found = 1'b1;
                ld_idx   = idx;
            end
        end
    end

    // Route load data: buffered waiter first, else the load entering now, else orphan
    always_comb begin
        ld_wr_en   = bus.mem_rdata_vld && ld_found;
        ld_to_new  = bus.mem_rdata_vld && !ld_found && push && bus.in_is_load;
        orphan_set = bus.mem_rdata_vld && !ld_found && !ld_to_new;

        push_entry.wb_en   = bus.in_wb_en;
        push_entry.is_load = bus.in_is_load;
        push_entry.dest    = bus.in_dest;
        push_entry.alu     = bus.in_alu;
        push_entry.data    = ld_to_new ? bus.mem_rdata : '0;
        push_entry.data_ok = !bus.in_is_load || ld_to_new;
    end

    // Head retires when its value is known, including load data bypassed this cycle
    always_comb begin
        head_bypass = ld_wr_en && (ld_idx == head_ptr);
        pop         = (count != '0) && (head.data_ok || head_bypass);
        if (!head.is_load)
            head_value = head.alu;
        else if (head.data_ok)
            head_value = head.data;
        else
            head_value = bus.mem_rdata;
    end

    // Registered retire outputs: GPR write pulse, or PC redirect for R15
    always_ff @(posedge clk) begin
        if (rst) begin
            dest_q   <= '0;
            result_q <= '0;
            wbe_q    <= 1'b0;
            pce_q    <= 1'b0;
            pcv_q    <= '0;
        end else begin
            wbe_q <= 1'b0;
            pce_q <= 1'b0;
            if (pop && head.wb_en) begin
                if (head.dest == PC_IDX) begin
                    pce_q <= 1'b1;
                    pcv_q <= head_value;
                end else begin
                    wbe_q    <= 1'b1;
                    dest_q   <= head.dest;
                    result_q <= head_value;
                end
            end
        end
    end

    // Sticky flag for load data that had no load to land in
    always_ff @(posedge clk) begin
        if (rst)
            orphan_q <= 1'b0;
        else if (orphan_set)
            orphan_q <= 1'b1;
    end

    // Registers with a write still in flight: buffered GPR writers plus the one on the port
    always_comb begin
        mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (entry_vld[k] && entries[k].wb_en && entries[k].dest != PC_IDX)
                mask[entries[k].dest] = 1'b1;
        end
        if (wbe_q)
            mask[dest_q] = 1'b1;
    end

    assign bus.destWB       = dest_q;
    assign bus.resultWB     = result_q;
    assign bus.writeBackEn  = wbe_q;
    assign bus.pc_wr_en     = pce_q;
    assign bus.pc_wr_value  = pcv_q;
    assign bus.pending_mask = mask;
    assign bus.rdata_orphan = orphan_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;
    import wb_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if #(.DATA_W(32), .REG_AW(4)) bus ();

    wb_stage #(.DEPTH(DEPTH), .DATA_W(32), .REG_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: list of pending results in program order
    typedef struct {
        bit          wb_en;
        bit          is_load;
        int unsigned dest;
        logic [31:0] alu;
        logic [31:0] data;
        bit          have;
    } ment_t;

    ment_t       q[$];
    logic [3:0]  e_dest = '0;
    logic [31:0] e_res  = '0;
    logic [31:0] e_pcv  = '0;
    bit          e_wbe  = 0;
    bit          e_pce  = 0;
    bit          e_orph = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        bit          acc;
        bit          placed;
        ment_t       ne;
        logic [31:0] v;
        if (rst) begin
            q.delete();
            e_dest = '0; e_res = '0; e_pcv = '0;
            e_wbe = 0; e_pce = 0; e_orph = 0;
            chk_en = 1;
        end else begin
            acc        = bus.in_valid && (q.size() < DEPTH);
            ne.wb_en   = bus.in_wb_en;
            ne.is_load = bus.in_is_load;
            ne.dest    = bus.in_dest;
            ne.alu     = bus.in_alu;
            ne.data    = '0;
            ne.have    = !bus.in_is_load;
            placed     = 0;
            if (bus.mem_rdata_vld) begin
                foreach (q[i]) begin
                    if (!placed && q[i].is_load && !q[i].have) begin
                        q[i].data = bus.mem_rdata;
                        q[i].have = 1;
                        placed = 1;
                    end
                end
                if (!placed) begin
                    if (acc && bus.in_is_load) begin
                        ne.data = bus.mem_rdata;
                        ne.have = 1;
                    end else begin
                        e_orph = 1;
                    end
                end
            end
            e_wbe = 0;
            e_pce = 0;
            if (q.size() > 0 && q[0].have) begin
                v = q[0].is_load ? q[0].data : q[0].alu;
                if (q[0].wb_en) begin
                    if (q[0].dest == 15) begin
                        e_pce = 1;
                        e_pcv = v;
                    end else begin
                        e_wbe  = 1;
                        e_dest = 4'(q[0].dest);
                        e_res  = v;
                    end
                end
                void'(q.pop_front());
            end
            if (acc)
                q.push_back(ne);
        end
    end

    // Compare every cycle against the model
    always @(negedge clk) begin
        logic [14:0] em;
        if (chk_en) begin
            em = '0;
            foreach (q[i])
                if (q[i].wb_en && q[i].dest < 15)
                    em[q[i].dest] = 1'b1;
            if (e_wbe)
                em[e_dest] = 1'b1;
            chk("in_ready",     32'(bus.in_ready),     32'(q.size() < DEPTH));
            chk("writeBackEn",  32'(bus.writeBackEn),  32'(e_wbe));
            chk("destWB",       32'(bus.destWB),       32'(e_dest));
            chk("resultWB",     bus.resultWB,          e_res);
            chk("pc_wr_en",     32'(bus.pc_wr_en),     32'(e_pce));
            chk("pc_wr_value",  bus.pc_wr_value,       e_pcv);
            chk("pending_mask", 32'(bus.pending_mask), 32'(em));
            chk("rdata_orphan", 32'(bus.rdata_orphan), 32'(e_orph));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid      = 1'b0;
        bus.in_wb_en      = 1'b0;
        bus.in_is_load    = 1'b0;
        bus.in_dest       = '0;
        bus.in_alu        = '0;
        bus.mem_rdata_vld = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    task automatic send(input bit we, input bit ld, input logic [3:0] d, input logic [31:0] a);
        bus.in_valid      = 1'b1;
        bus.in_wb_en      = we;
        bus.in_is_load    = ld;
        bus.in_dest       = d;
        bus.in_alu        = a;
        bus.mem_rdata_vld = 1'b0;
        bus.mem_rdata     = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wbe",     32'(bus.writeBackEn),  32'd0);
        chk("rst_pce",     32'(bus.pc_wr_en),     32'd0);
        chk("rst_ready",   32'(bus.in_ready),     32'd1);
        chk("rst_mask",    32'(bus.pending_mask), 32'd0);
        chk("rst_orphan",  32'(bus.rdata_orphan), 32'd0);
        chk("rst_destWB",  32'(bus.destWB),       32'd0);
        chk("rst_result",  bus.resultWB,          32'd0);
        chk("rst_pcv",     bus.pc_wr_value,       32'd0);

        // ALU write to R3
        send(1, 0, 4'd3, 32'h1234);
        tick();
        idle();
        chk("alu_mask_n",  32'(bus.pending_mask), 32'h8);
        chk("alu_wbe_n",   32'(bus.writeBackEn),  32'd0);
        tick();
        chk("alu_wbe",     32'(bus.writeBackEn),  32'd1);
        chk("alu_dest",    32'(bus.destWB),       32'd3);
        chk("alu_res",     bus.resultWB,          32'h1234);
        chk("alu_mask",    32'(bus.pending_mask), 32'h8);
        tick();
        chk("alu_wbe_end", 32'(bus.writeBackEn),  32'd0);
        chk("alu_mask_end",32'(bus.pending_mask), 32'd0);

        // Load stall: load R5, then ALU R6, data three edges after the load
        send(1, 1, 4'd5, 32'h0);
        tick();
        send(1, 0, 4'd6, 32'd7);
        tick();
        chk("full_ready",  32'(bus.in_ready),     32'd0);
        chk("full_mask",   32'(bus.pending_mask), 32'h60);
        send(1, 0, 4'd9, 32'd99);
        tick();
        chk("full_ready2", 32'(bus.in_ready),     32'd0);
        chk("stall_wbe",   32'(bus.writeBackEn),  32'd0);
        idle();
        bus.mem_rdata_vld = 1'b1;
        bus.mem_rdata     = 32'hCAFE;
        tick();
        idle();
        chk("ld_wbe",      32'(bus.writeBackEn),  32'd1);
        chk("ld_dest",     32'(bus.destWB),       32'd5);
        chk("ld_res",      bus.resultWB,          32'hCAFE);
        chk("ld_ready",    32'(bus.in_ready),     32'd1);
        tick();
        chk("r6_dest",     32'(bus.destWB),       32'd6);
        chk("r6_res",      bus.resultWB,          32'd7);
        tick();
        chk("r6_end",      32'(bus.writeBackEn),  32'd0);

        // Load data arriving in the accept cycle
        send(1, 1, 4'd7, 32'h0);
        bus.mem_rdata_vld = 1'b1;
        bus.mem_rdata     = 32'h55;
        tick();
        idle();
        tick();
        chk("early_wbe",   32'(bus.writeBackEn),  32'd1);
        chk("early_dest",  32'(bus.destWB),       32'd7);
        chk("early_res",   bus.resultWB,          32'h55);
        chk("early_orph",  32'(bus.rdata_orphan), 32'd0);

        // R15 redirect
        send(1, 0, 4'd15, 32'h100);
        tick();
        idle();
        chk("r15_mask",    32'(bus.pending_mask), 32'd0);
        tick();
        chk("r15_pce",     32'(bus.pc_wr_en),     32'd1);
        chk("r15_pcv",     bus.pc_wr_value,       32'h100);
        chk("r15_wbe",     32'(bus.writeBackEn),  32'd0);
        tick();
        chk("r15_pce_end", 32'(bus.pc_wr_en),     32'd0);

        // Silent retire keeps previous write-port values
        send(0, 0, 4'd2, 32'd77);
        tick();
        idle();
        tick();
        chk("sil_wbe",     32'(bus.writeBackEn),  32'd0);
        chk("sil_dest",    32'(bus.destWB),       32'd7);
        chk("sil_res",     bus.resultWB,          32'h55);

        // Streaming one result per cycle across pointer wrap
        for (int i = 1; i <= 5; i++) begin
            send(1, 0, 4'(i), 32'(i * 16));
            tick();
            if (i >= 2) begin
                chk("stream_dest", 32'(bus.destWB), 32'(i - 1));
                chk("stream_res",  bus.resultWB,    32'((i - 1) * 16));
            end
        end
        idle();
        tick();
        chk("stream_last", 32'(bus.destWB), 32'd5);
        tick();

        // Reset while a load waits; its data becomes an orphan
        send(1, 1, 4'd8, 32'h0);
        tick();
        idle();
        tick();
        chk("ml_mask",     32'(bus.pending_mask), 32'h100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ml_mask_rst", 32'(bus.pending_mask), 32'd0);
        bus.mem_rdata_vld = 1'b1;
        bus.mem_rdata     = 32'hBEEF;
        tick();
        idle();
        chk("ml_orph",     32'(bus.rdata_orphan), 32'd1);
        chk("ml_wbe",      32'(bus.writeBackEn),  32'd0);
        tick();
        chk("ml_wbe2",     32'(bus.writeBackEn),  32'd0);
        chk("ml_orph2",    32'(bus.rdata_orphan), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("orph_clr",    32'(bus.rdata_orphan), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
